lcd_hd44780_ctrl: RTL and testbench

LCD_HD44780_CTRL -- requirements
Module: lcd_hd44780_ctrl

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_bus_writer.sv | 132 +++++++++++++
 rtl/lcd_hd44780_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_lcd_hd44780_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, state types and DDRAM row addressing for the HD44780 controller.
package lcd_pkg;

  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] ENTRY     = 8'h06;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] FUNC8     = 8'h38;
  localparam logic [7:0] FUNC4     = 8'h28;
  localparam logic [7:0] SET_DDRAM = 8'h80;
  // Wake-up nibbles for 4-bit init, carried in the high half of the byte.
  localparam logic [7:0] WAKE_3    = 8'h30;
  localparam logic [7:0] WAKE_2    = 8'h20;

  typedef enum logic [1:0] {ST_INIT, ST_ROW_ADDR, ST_CHARS, ST_FRAME_END} lcd_state_t;
  typedef enum logic [2:0] {W_IDLE, W_E_HI, W_E_LO, W_SETTLE, W_NIB2} wr_phase_t;

  function automatic logic [7:0] row_base(input logic [1:0] row, input logic [7:0] cols);
    case (row)
      2'd0:    row_base = 8'h00;
      2'd1:    row_base = 8'h40;
      2'd2:    row_base = cols;
      2'd3:    row_base = 8'h40 + cols;
      default: row_base = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// One HD44780 bus transfer (byte, or nibble pair in 4-bit mode) paced by the bus tick.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int BUS_4BIT     = 0,
  parameter int SETTLE_TICKS = 100,
  parameter int CLEAR_TICKS  = 1000
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       tick,
  input  logic       start,
  input  logic       nibble_only,
  input  logic       byte_rs,
  input  logic [7:0] byte_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] lcd_data,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       lcd_rs
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_TICKS - 1);
  localparam logic [15:0] CLEAR_LAST  = 16'(CLEAR_TICKS - 1);

  wr_phase_t   phase_r, phase_n;
  logic [15:0] cnt_r, cnt_n, settle_last_s;
  logic [7:0]  byte_r, byte_n, data_r, data_n;
  logic        e_r, e_n, rs_r, rs_n, second_r, second_n, clear_r, clear_n, done_s;

  // Transfer sequencer: tick 0 drive, tick 1 E high, tick 2 E low, then settle.
  always_comb begin
    phase_n  = phase_r;
    cnt_n    = cnt_r;
    byte_n   = byte_r;
    data_n   = data_r;
    e_n      = e_r;
    rs_n     = rs_r;
    second_n = second_r;
    clear_n  = clear_r;
    done_s   = 1'b0;
    // The long clear delay belongs after the final nibble only.
    settle_last_s = (clear_r && !second_r) ? CLEAR_LAST : SETTLE_LAST;
    case (phase_r)
      W_IDLE: begin
        if (start) begin
          byte_n   = byte_data;
          rs_n     = byte_rs;
          data_n   = (BUS_4BIT != 0) ? {byte_data[7:4], 4'h0} : byte_data;
          second_n = (BUS_4BIT != 0) && !nibble_only;
          clear_n  = !byte_rs && (byte_data == CLEAR);
          phase_n  = W_E_HI;
        end else begin
          phase_n = W_IDLE;
        end
      end
      W_E_HI: begin
        if (tick) begin
          e_n     = 1'b1;
          phase_n = W_E_LO;
        end else begin
          phase_n = W_E_HI;
        end
      end
      W_E_LO: begin
        if (tick) begin
          e_n     = 1'b0;
          cnt_n   = 16'd0;
          phase_n = W_SETTLE;
        end else begin
          phase_n = W_E_LO;
        end
      end
      W_SETTLE: begin
        if (tick && (cnt_r == settle_last_s)) begin
          if (second_r) begin
            phase_n = W_NIB2;
          end else begin
            phase_n = W_IDLE;
            done_s  = 1'b1;
          end
        end else if (tick) begin
          cnt_n = cnt_r + 16'd1;
        end else begin
          cnt_n = cnt_r;
        end
      end
      W_NIB2: begin
        if (tick) begin
          data_n   = {byte_r[3:0], 4'h0};
          second_n = 1'b0;
          phase_n  = W_E_HI;
        end else begin
          phase_n = W_NIB2;
        end
      end
      default: phase_n = W_IDLE;
    endcase
  end

  // Transfer state and bus output registers; reset drops E asynchronously.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      phase_r  <= W_IDLE;
      cnt_r    <= 16'd0;
      byte_r   <= 8'h00;
      data_r   <= 8'h00;
      e_r      <= 1'b0;
      rs_r     <= 1'b0;
      second_r <= 1'b0;
      clear_r  <= 1'b0;
    end else begin
      phase_r  <= phase_n;
      cnt_r    <= cnt_n;
      byte_r   <= byte_n;
      data_r   <= data_n;
      e_r      <= e_n;
      rs_r     <= rs_n;
      second_r <= second_n;
      clear_r  <= clear_n;
    end
  end

  assign busy     = (phase_r != W_IDLE);
  assign done     = done_s;
  assign lcd_data = data_r;
  assign lcd_e    = e_r;
  assign lcd_rs   = rs_r;
  assign lcd_rw   = 1'b0;

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 character LCD controller: init sequence, then endless refresh of a host-written buffer.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int CLK_DIV      = 240,
  parameter int SETTLE_TICKS = 100,
  parameter int CLEAR_TICKS  = 1000,
  parameter int ROWS         = 2,
  parameter int COLS         = 16,
  parameter int BUS_4BIT     = 0,
  localparam int DEPTH       = ROWS * COLS,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          clock_in,
  input  logic          reset_in,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic [7:0]    lcd_data,
  output logic          lcd_e,
  output logic          lcd_rw,
  output logic          lcd_rs,
  output logic          init_done,
  output logic          frame_done
);

  localparam logic [2:0] INIT_LAST = (BUS_4BIT != 0) ? 3'd7 : 3'd4;

  lcd_state_t    state_r, state_n;
  logic [15:0]   div_r;
  logic [2:0]    step_r, step_n;
  logic [1:0]    row_r, row_n;
  logic [4:0]    col_r, col_n;
  logic [AW-1:0] addr_r, addr_n;
  logic [7:0]    buf_r [DEPTH];
  logic [7:0]    tx_data_s;
  logic          tick_s, start_s, tx_rs_s, tx_nib_s, busy_s, done_s;
  logic          init_done_r, frame_done_r;

  function automatic logic [7:0] init_byte(input logic [2:0] step);
    if (BUS_4BIT != 0) begin
      case (step)
        3'd0, 3'd1, 3'd2: init_byte = WAKE_3;
        3'd3:             init_byte = WAKE_2;
        3'd4:             init_byte = FUNC4;
        3'd5:             init_byte = DISP_ON;
        3'd6:             init_byte = ENTRY;
        default:          init_byte = CLEAR;
      endcase
    end else begin
      case (step)
        3'd0, 3'd1: init_byte = FUNC8;
        3'd2:       init_byte = DISP_ON;
        3'd3:       init_byte = ENTRY;
        default:    init_byte = CLEAR;
      endcase
    end
  endfunction

  assign tick_s = (div_r == 16'(CLK_DIV - 1));

  // Bus tick divider.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) div_r <= 16'd0;
    else if (tick_s) div_r <= 16'd0;
    else div_r <= div_r + 16'd1;
  end

  // Sequencer: picks the next byte and advances when the writer reports completion.
  always_comb begin
    state_n   = state_r;
    step_n    = step_r;
    row_n     = row_r;
    col_n     = col_r;
    addr_n    = addr_r;
    tx_data_s = 8'h00;
    tx_rs_s   = 1'b0;
    tx_nib_s  = 1'b0;
    case (state_r)
      ST_INIT: begin
        tx_data_s = init_byte(step_r);
        tx_nib_s  = (BUS_4BIT != 0) && (step_r < 3'd4);
        if (done_s && (step_r == INIT_LAST)) begin
          step_n  = 3'd0;
          state_n = ST_ROW_ADDR;
        end else if (done_s) begin
          step_n = step_r + 3'd1;
        end else begin
          step_n = step_r;
        end
      end
      ST_ROW_ADDR: begin
        tx_data_s = SET_DDRAM | row_base(row_r, 8'(COLS));
        if (done_s) begin
          col_n   = 5'd0;
          state_n = ST_CHARS;
        end else begin
          state_n = ST_ROW_ADDR;
        end
      end
      ST_CHARS: begin
        tx_data_s = buf_r[addr_r];
        tx_rs_s   = 1'b1;
        if (done_s && (col_r == 5'(COLS - 1))) begin
          addr_n = addr_r + 1'b1;
          col_n  = 5'd0;
          if (row_r == 2'(ROWS - 1)) begin
            state_n = ST_FRAME_END;
          end else begin
            row_n   = row_r + 2'd1;
            state_n = ST_ROW_ADDR;
          end
        end else if (done_s) begin
          addr_n = addr_r + 1'b1;
          col_n  = col_r + 5'd1;
        end else begin
          state_n = ST_CHARS;
        end
      end
      ST_FRAME_END: begin
        row_n   = 2'd0;
        addr_n  = '0;
        state_n = ST_ROW_ADDR;
      end
      default: state_n = ST_INIT;
    endcase
    // A start coincides with a tick, so the byte (and buffer read) is captured at tick 0.
    start_s = tick_s && !busy_s && (state_r != ST_FRAME_END);
  end

  // Sequencer state and status flags.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_r      <= ST_INIT;
      step_r       <= 3'd0;
      row_r        <= 2'd0;
      col_r        <= 5'd0;
      addr_r       <= '0;
      init_done_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      step_r       <= step_n;
      row_r        <= row_n;
      col_r        <= col_n;
      addr_r       <= addr_n;
      init_done_r  <= init_done_r | ((state_r == ST_INIT) && done_s && (step_r == INIT_LAST));
      frame_done_r <= (state_n == ST_FRAME_END);
    end
  end

  // Character buffer; out-of-range writes are dropped.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < DEPTH; i++) buf_r[i] <= 8'h20;
    end else if (wr_en && ({{(32 - AW){1'b0}}, wr_addr} < 32'(DEPTH))) begin
      buf_r[wr_addr] <= wr_data;
    end
  end

  lcd_bus_writer #(
    .BUS_4BIT    (BUS_4BIT),
    .SETTLE_TICKS(SETTLE_TICKS),
    .CLEAR_TICKS (CLEAR_TICKS)
  ) u_writer (
    .clock_in   (clock_in),
    .reset_in   (reset_in),
    .tick       (tick_s),
    .start      (start_s),
    .nibble_only(tx_nib_s),
    .byte_rs    (tx_rs_s),
    .byte_data  (tx_data_s),
    .busy       (busy_s),
    .done       (done_s),
    .lcd_data   (lcd_data),
    .lcd_e      (lcd_e),
    .lcd_rw     (lcd_rw),
    .lcd_rs     (lcd_rs)
  );

  assign init_done  = init_done_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench: three controller configurations, expected bus bytes queued, checked on each E pulse.
module tb_lcd_hd44780_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_chk = 0;
  int n_err = 0;

  // a: 8-bit 2x16, b: 4-bit 2x16, c: 8-bit 4x20
  logic       a_wr_en, b_wr_en, c_wr_en;
  logic [4:0] a_wr_addr, b_wr_addr;
  logic [6:0] c_wr_addr;
  logic [7:0] a_wr_data, b_wr_data, c_wr_data;
  logic [7:0] a_data, b_data, c_data;
  logic       a_e, a_rw, a_rs, a_idone, a_fd;
  logic       b_e, b_rw, b_rs, b_idone, b_fd;
  logic       c_e, c_rw, c_rs, c_idone, c_fd;

  lcd_hd44780_ctrl #(.CLK_DIV(2), .SETTLE_TICKS(4), .CLEAR_TICKS(8), .ROWS(2), .COLS(16), .BUS_4BIT(0)) u_dut8 (
    .clock_in(clk), .reset_in(rst_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .lcd_data(a_data), .lcd_e(a_e), .lcd_rw(a_rw), .lcd_rs(a_rs), .init_done(a_idone), .frame_done(a_fd));
  lcd_hd44780_ctrl #(.CLK_DIV(2), .SETTLE_TICKS(4), .CLEAR_TICKS(8), .ROWS(2), .COLS(16), .BUS_4BIT(1)) u_dut4 (
    .clock_in(clk), .reset_in(rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .lcd_data(b_data), .lcd_e(b_e), .lcd_rw(b_rw), .lcd_rs(b_rs), .init_done(b_idone), .frame_done(b_fd));
  lcd_hd44780_ctrl #(.CLK_DIV(2), .SETTLE_TICKS(4), .CLEAR_TICKS(8), .ROWS(4), .COLS(20), .BUS_4BIT(0)) u_dut20 (
    .clock_in(clk), .reset_in(rst_n), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
    .lcd_data(c_data), .lcd_e(c_e), .lcd_rw(c_rw), .lcd_rs(c_rs), .init_done(c_idone), .frame_done(c_fd));

  // Expected {rs, data} per E pulse.
  logic [8:0] qa[$], qb[$], qc[$];
  logic       mon_a = 1'b0, mon_b = 1'b0, mon_c = 1'b0;
  logic       a_e_prev = 1'b0, b_e_prev = 1'b0, c_e_prev = 1'b0;
  int         a_fd_cnt = 0, c_fd_cnt = 0, a_frames = 0, c_frames = 0;
  logic [7:0] m8 [32];
  logic [7:0] m20 [80];
  logic [7:0] base20 [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out, qa=%0d qb=%0d qc=%0d left", name, qa.size(), qb.size(), qc.size());
  endtask

  task automatic push_frame8();
    qa.push_back(9'h080);
    for (int i = 0; i < 32; i++) begin
      if (i == 16) qa.push_back(9'h0C0);
      qa.push_back({1'b1, m8[i]});
    end
  endtask

  task automatic wr_a(input logic [4:0] ad, input logic [7:0] d);
    @(posedge clk); #1;
    a_wr_en = 1'b1; a_wr_addr = ad; a_wr_data = d;
    @(posedge clk); #1;
    a_wr_en = 1'b0;
  endtask

  task automatic wr_c(input logic [6:0] ad, input logic [7:0] d);
    @(posedge clk); #1;
    c_wr_en = 1'b1; c_wr_addr = ad; c_wr_data = d;
    @(posedge clk); #1;
    c_wr_en = 1'b0;
  endtask

  // Monitor, 8-bit 2x16
  always @(negedge clk) begin
    logic [8:0] ex;
    if (mon_a && a_e && !a_e_prev && (qa.size() > 0)) begin
      ex = qa.pop_front();
      check("dut8_byte", {22'd0, a_rw, a_rs, a_data}, {22'd0, 1'b0, ex});
      if (ex == 9'h001) check("dut8_init_done_before_clear_settles", {31'd0, a_idone}, 32'd0);
      if (ex == 9'h080) begin
        check("dut8_frame_done_pulses", a_fd_cnt, a_frames);
        check("dut8_init_done", {31'd0, a_idone}, 32'd1);
        a_frames++;
      end
    end
    if (a_fd) a_fd_cnt++;
    a_e_prev <= a_e;
  end

  // Monitor, 4-bit: full byte compare also proves lcd_data[3:0] is zero
  always @(negedge clk) begin
    logic [8:0] ex;
    if (mon_b && b_e && !b_e_prev && (qb.size() > 0)) begin
      ex = qb.pop_front();
      check("dut4_nibble", {22'd0, b_rw, b_rs, b_data}, {22'd0, 1'b0, ex});
    end
    b_e_prev <= b_e;
  end

  // Monitor, 8-bit 4x20
  always @(negedge clk) begin
    logic [8:0] ex;
    if (mon_c && c_e && !c_e_prev && (qc.size() > 0)) begin
      ex = qc.pop_front();
      check("dut20_byte", {22'd0, c_rw, c_rs, c_data}, {22'd0, 1'b0, ex});
      if (ex == 9'h080) begin
        check("dut20_frame_done_pulses", c_fd_cnt, c_frames);
        c_frames++;
      end
    end
    if (c_fd) c_fd_cnt++;
    c_e_prev <= c_e;
  end

  initial begin
    int t;
    rst_n = 1'b0;
    a_wr_en = 1'b0; a_wr_addr = 5'd0; a_wr_data = 8'h00;
    b_wr_en = 1'b0; b_wr_addr = 5'd0; b_wr_data = 8'h00;
    c_wr_en = 1'b0; c_wr_addr = 7'd0; c_wr_data = 8'h00;
    base20[0] = 8'h80; base20[1] = 8'hC0; base20[2] = 8'h94; base20[3] = 8'hD4;
    repeat (3) @(posedge clk);
    #1;
    check("reset_lcd_data", {24'd0, a_data}, 32'h00);
    check("reset_lcd_e", {29'd0, a_e, b_e, c_e}, 32'd0);
    check("reset_rs_rw", {26'd0, a_rs, a_rw, b_rs, b_rw, c_rs, c_rw}, 32'd0);
    check("reset_init_done", {29'd0, a_idone, b_idone, c_idone}, 32'd0);
    check("reset_frame_done", {29'd0, a_fd, b_fd, c_fd}, 32'd0);
    check("reset_lcd_data_4bit", {24'd0, b_data}, 32'h00);

    // 8-bit init, then two frames and the start of a third
    foreach (qa[i]) qa.delete(i);
    qa.push_back(9'h038); qa.push_back(9'h038); qa.push_back(9'h00C);
    qa.push_back(9'h006); qa.push_back(9'h001);
    for (int i = 0; i < 32; i++) m8[i] = 8'h20;
    m8[0] = 8'h41; m8[17] = 8'h42; m8[4] = 8'h44;
    push_frame8();
    m8[5] = 8'h55;
    push_frame8();
    qa.push_back(9'h080);

    // 4-bit init nibbles followed by the row-0 address command
    qb.push_back(9'h030); qb.push_back(9'h030); qb.push_back(9'h030); qb.push_back(9'h020);
    qb.push_back(9'h020); qb.push_back(9'h080); qb.push_back(9'h000); qb.push_back(9'h0C0);
    qb.push_back(9'h000); qb.push_back(9'h060); qb.push_back(9'h000); qb.push_back(9'h010);
    qb.push_back(9'h080); qb.push_back(9'h000);

    // 4x20: out-of-range write at 80 dropped, last cell 79 written
    qc.push_back(9'h038); qc.push_back(9'h038); qc.push_back(9'h00C);
    qc.push_back(9'h006); qc.push_back(9'h001);
    for (int i = 0; i < 80; i++) m20[i] = 8'h20;
    m20[79] = 8'h5A;
    for (int r = 0; r < 4; r++) begin
      qc.push_back({1'b0, base20[r]});
      for (int cc = 0; cc < 20; cc++) qc.push_back({1'b1, m20[r * 20 + cc]});
    end
    qc.push_back(9'h080);

    mon_a = 1'b1; mon_b = 1'b1; mon_c = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    wr_a(5'd0, 8'h41);
    wr_a(5'd17, 8'h42);
    wr_a(5'd4, 8'h44);
    wr_c(7'd80, 8'h58);
    wr_c(7'd79, 8'h5A);

    // Write addr 5 in the very cycle char 5 is latched: E of char 4 falls, then 4 settle ticks,
    // the next tick (10 clocks after the fall) latches char 5.
    t = 0;
    while (!(a_e && a_rs && (a_data == 8'h44)) && (t < 5000)) begin @(negedge clk); t++; end
    if (t >= 5000) timeout("wait_char4");
    t = 0;
    while (a_e && (t < 20)) begin @(negedge clk); t++; end
    if (t >= 20) timeout("wait_char4_e_fall");
    repeat (9) @(posedge clk);
    #1;
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 8'h55;
    @(posedge clk); #1;
    a_wr_en = 1'b0;

    t = 0;
    while (((qa.size() + qb.size() + qc.size()) > 0) && (t < 20000)) begin @(negedge clk); t++; end
    if (t >= 20000) timeout("main_stream");

    // Reset in the middle of an E pulse: E drops at once, init restarts from the top
    mon_a = 1'b0; mon_b = 1'b0; mon_c = 1'b0;
    t = 0;
    while (!a_e && (t < 200)) begin @(negedge clk); t++; end
    if (t >= 200) timeout("wait_e_high");
    check("e_high_before_reset", {31'd0, a_e}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("e_drops_async", {31'd0, a_e}, 32'd0);
    check("init_done_cleared", {30'd0, a_idone, b_idone}, 32'd0);
    qa.delete(); qb.delete(); qc.delete();
    qa.push_back(9'h038); qa.push_back(9'h038);
    qb.push_back(9'h030); qb.push_back(9'h030);
    mon_a = 1'b1; mon_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    t = 0;
    while (((qa.size() + qb.size()) > 0) && (t < 500)) begin @(negedge clk); t++; end
    if (t >= 500) timeout("restart_stream");
    mon_a = 1'b0; mon_b = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
